cpu_sequencer: RTL and testbench

Multi-cycle control FSM for the MIPS CPU. It sequences each instruction through fetch, execute, memory and writeback, and drives the program counter's update/jump controls (`update_pc`, `jump_r`, `jump_const`, `halt`). It also drives the Avalon-style memory read/write strobes, honouring `waitrequest`, and the instruction/register write enables. It sits between the memory bus, the decoded instruction register and the PC block. It owns `active` and the retired-instruction counter.

---
 rtl/cpu_sequencer.sv | 152 +++++++++++++++
 tb/tb_cpu_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/EXEC/MEM/WB control FSM for the MIPS CPU.
// Ports: clk, reset, pc, opcode, funct, branch_taken, waitrequest in;
//   memory strobes, ir/reg enables, pc controls, halt, active, state,
//   instr_count out.
module cpu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        branch_taken,
  input  logic        waitrequest,
  output logic        mem_read,
  output logic        mem_write,
  output logic        addr_sel,
  output logic        ir_write,
  output logic        reg_write,
  output logic        update_pc,
  output logic        jump_r,
  output logic        jump_const,
  output logic        halt,
  output logic        active,
  output logic [2:0]  state,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC  = 3'd1,
    S_MEM   = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        taken_q, taken_d;
  logic [31:0] cnt_q, cnt_d;

  logic is_load, is_store, is_bcc;
  logic is_jr, is_j, is_rw;

  always_comb begin
    is_load  = (opcode >= 6'h20) &&
               (opcode <= 6'h26);
    is_store = (opcode == 6'h28) ||
               (opcode == 6'h29) ||
               (opcode == 6'h2B);
    is_bcc   = (opcode >= 6'h01) &&
               (opcode <= 6'h07) &&
               (opcode != 6'h02) &&
               (opcode != 6'h03);
    is_jr    = (opcode == 6'h00) &&
               ((funct == 6'h08) ||
                (funct == 6'h09));
    is_j     = (opcode == 6'h02) ||
               (opcode == 6'h03);
    is_rw    = ((opcode == 6'h00) &&
                (funct != 6'h08)) ||
               (opcode == 6'h03) ||
               ((opcode >= 6'h08) &&
                (opcode <= 6'h0F)) ||
               is_load;
  end

  always_comb begin
    state_d    = state_q;
    taken_d    = taken_q;
    cnt_d      = cnt_q;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    addr_sel   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    update_pc  = 1'b0;
    jump_r     = 1'b0;
    jump_const = 1'b0;
    halt       = 1'b0;
    active     = 1'b0;
    case (state_q)
      S_FETCH: begin
        active = 1'b1;
        // pc==0 is the halt sentinel; no bus access.
        if (pc == 32'd0) begin
          state_d = S_HALT;
        end else begin
          mem_read = 1'b1;
          if (!waitrequest) begin
            ir_write = 1'b1;
            state_d  = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        active  = 1'b1;
        taken_d = branch_taken;
        state_d = (is_load || is_store) ?
                  S_MEM : S_WB;
      end
      S_MEM: begin
        active    = 1'b1;
        addr_sel  = 1'b1;
        mem_read  = is_load;
        mem_write = is_store;
        if (!waitrequest) state_d = S_WB;
      end
      S_WB: begin
        active     = 1'b1;
        update_pc  = 1'b1;
        jump_r     = is_jr;
        jump_const = is_j || (is_bcc && taken_q);
        reg_write  = is_rw;
        cnt_d      = cnt_q + 32'd1;
        state_d    = S_FETCH;
      end
      S_HALT: begin
        halt = 1'b1;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
    // Reset forces every output low, even mid-transfer.
    if (reset) begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      addr_sel   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      update_pc  = 1'b0;
      jump_r     = 1'b0;
      jump_const = 1'b0;
      halt       = 1'b0;
      active     = 1'b0;
    end
  end

  assign state       = reset ? 3'd0  : state_q;
  assign instr_count = reset ? 32'd0 : cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      taken_q <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      taken_q <= taken_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: instruction-level reference model for cpu_sequencer,
// directed test-plan cases followed by randomized instruction streams.
module tb_cpu_sequencer;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        branch_taken;
  logic        waitrequest;
  logic        mem_read, mem_write, addr_sel, ir_write;
  logic        reg_write, update_pc, jump_r, jump_const;
  logic        halt, active;
  logic [2:0]  state;
  logic [31:0] instr_count;

  cpu_sequencer dut (
    .clk(clk), .reset(reset), .pc(pc),
    .opcode(opcode), .funct(funct),
    .branch_taken(branch_taken),
    .waitrequest(waitrequest),
    .mem_read(mem_read), .mem_write(mem_write),
    .addr_sel(addr_sel), .ir_write(ir_write),
    .reg_write(reg_write), .update_pc(update_pc),
    .jump_r(jump_r), .jump_const(jump_const),
    .halt(halt), .active(active),
    .state(state), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [12:0] exp_o;
  logic [31:0] exp_cnt;
  logic        chk_en = 1'b0;
  logic [31:0] mcnt = 0;

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got=%h want=%h",
               nm, $time, got, want);
    end
  endtask

  // One comparison process for every driven cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("outs",
            {19'd0, mem_read, mem_write, addr_sel,
             ir_write, reg_write, update_pc, jump_r,
             jump_const, halt, active, state},
            {19'd0, exp_o});
      check("instr_count", instr_count, exp_cnt);
    end
  end

  // Packed expectation:
  // {mr,mw,as,ir,rw,up,jr,jc,halt,active,state}
  function automatic logic [12:0] mk(
    bit mr, bit mw, bit as, bit ir, bit rw,
    bit up, bit jr, bit jc, bit h, bit a,
    logic [2:0] st);
    return {mr, mw, as, ir, rw, up, jr, jc, h, a, st};
  endfunction

  function automatic bit m_load(logic [5:0] op);
    return op inside {[6'h20:6'h26]};
  endfunction
  function automatic bit m_store(logic [5:0] op);
    return op inside {6'h28, 6'h29, 6'h2B};
  endfunction
  function automatic bit m_jr(logic [5:0] op,
                              logic [5:0] fn);
    return op == 0 && fn inside {6'h08, 6'h09};
  endfunction
  function automatic bit m_jc(logic [5:0] op, bit bt);
    if (op inside {6'h02, 6'h03}) return 1'b1;
    if (op inside {6'h01, [6'h04:6'h07]}) return bt;
    return 1'b0;
  endfunction
  function automatic bit m_rw(logic [5:0] op,
                              logic [5:0] fn);
    if (op == 0) return fn != 6'h08;
    if (op == 6'h03) return 1'b1;
    if (op inside {[6'h08:6'h0F]}) return 1'b1;
    return m_load(op);
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Drive one clock cycle and state what the outputs must be in it.
  task automatic cyc(input bit rst, input bit wr,
                     input bit bt, input logic [12:0] e);
    reset        = rst;
    waitrequest  = wr;
    branch_taken = bt;
    exp_o        = e;
    exp_cnt      = rst ? 32'd0 : mcnt;
    chk_en       = 1'b1;
    @(posedge clk);
    #1;
    if (rst) mcnt = 0;
  endtask

  // Expand one instruction into its expected cycle sequence.
  task automatic instr(input logic [31:0] p,
                       input logic [5:0] op,
                       input logic [5:0] fn,
                       input bit bt, input int fs,
                       input int ms, output int lat);
    bit ld, sw;
    ld = m_load(op);
    sw = m_store(op);
    pc = p; opcode = op; funct = fn;
    lat = 0;
    for (int i = 0; i < fs; i++) begin
      cyc(0, 1, rb(),
          mk(1,0,0,0,0,0,0,0,0,1,3'd0));
      lat++;
    end
    cyc(0, 0, rb(), mk(1,0,0,1,0,0,0,0,0,1,3'd0));
    lat++;
    cyc(0, rb(), bt, mk(0,0,0,0,0,0,0,0,0,1,3'd1));
    lat++;
    if (ld || sw) begin
      for (int i = 0; i < ms; i++) begin
        cyc(0, 1, rb(),
            mk(ld,sw,1,0,0,0,0,0,0,1,3'd2));
        lat++;
      end
      cyc(0, 0, rb(), mk(ld,sw,1,0,0,0,0,0,0,1,3'd2));
      lat++;
    end
    cyc(0, rb(), rb(),
        mk(0,0,0,0,m_rw(op,fn),1,m_jr(op,fn),
           m_jc(op,bt),0,1,3'd3));
    lat++;
    mcnt = mcnt + 1;
  endtask

  task automatic do_halt(input int n);
    pc = 0;
    cyc(0, rb(), rb(), mk(0,0,0,0,0,0,0,0,0,1,3'd0));
    for (int i = 0; i < n; i++) begin
      pc = $urandom | 32'd1;
      cyc(0, rb(), rb(),
          mk(0,0,0,0,0,0,0,0,1,0,3'd4));
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++)
      cyc(1, rb(), rb(), 13'd0);
  endtask

  logic [5:0] ops [22] = '{
    6'h00, 6'h02, 6'h03, 6'h01, 6'h04, 6'h05,
    6'h06, 6'h07, 6'h08, 6'h09, 6'h0F, 6'h20,
    6'h23, 6'h26, 6'h28, 6'h29, 6'h2B, 6'h27,
    6'h2A, 6'h3F, 6'h10, 6'h1C};
  logic [5:0] fns [5] = '{
    6'h08, 6'h09, 6'h20, 6'h21, 6'h2A};

  initial begin
    int lat;
    logic [5:0] op, fn;
    reset = 1; pc = 32'hBFC00000;
    opcode = 0; funct = 0;
    branch_taken = 0; waitrequest = 0;
    @(posedge clk);
    #1;
    do_reset(2);

    // ADDIU, no stalls: 3 cycles, one retired.
    instr(32'hBFC00000, 6'h09, 6'h00, 0, 0, 0, lat);
    check("addiu_lat", lat, 32'd3);
    check("addiu_cnt", instr_count, 32'd1);

    // LW with 2 fetch stalls and 3 mem stalls.
    instr(32'hBFC00004, 6'h23, 6'h00, 0, 2, 3, lat);
    check("lw_lat", lat, 32'd9);
    check("lw_cnt", instr_count, 32'd2);

    instr(32'hBFC00008, 6'h2B, 6'h00, 0, 0, 1, lat);
    check("sw_lat", lat, 32'd5);
    instr(32'hBFC0000C, 6'h04, 6'h00, 1, 0, 0, lat);
    instr(32'hBFC00010, 6'h04, 6'h00, 0, 0, 0, lat);
    instr(32'hBFC00014, 6'h00, 6'h08, 0, 0, 0, lat);
    instr(32'hBFC00018, 6'h03, 6'h00, 0, 1, 0, lat);
    check("cnt7", instr_count, 32'd7);

    // Halt, park for 20 cycles, then reset.
    do_halt(20);
    check("halt_lvl", {31'd0, halt}, 32'd1);
    do_reset(1);
    check("post_rst_cnt", instr_count, 32'd0);
    check("post_rst_state", {29'd0, state}, 32'd0);

    // Reset while a load stalls in MEM.
    instr(32'h00400000, 6'h09, 6'h00, 0, 0, 0, lat);
    pc = 32'h00400004; opcode = 6'h23; funct = 0;
    cyc(0, 0, 0, mk(1,0,0,1,0,0,0,0,0,1,3'd0));
    cyc(0, 0, 0, mk(0,0,0,0,0,0,0,0,0,1,3'd1));
    cyc(0, 1, 0, mk(1,0,1,0,0,0,0,0,0,1,3'd2));
    cyc(1, 1, 0, 13'd0);
    check("midmem_rst_cnt", instr_count, 32'd0);
    instr(32'h00400004, 6'h23, 6'h00, 0, 0, 0, lat);

    // Reset on the completing fetch cycle: no ir_write.
    pc = 32'h00400008; opcode = 6'h09;
    cyc(1, 0, 0, 13'd0);
    instr(32'h00400008, 6'h09, 6'h00, 0, 0, 0, lat);

    // Randomized instruction stream.
    for (int k = 0; k < 200; k++) begin
      op = ops[$urandom_range(0, 21)];
      fn = ($urandom_range(0, 3) == 0) ?
           6'($urandom) : fns[$urandom_range(0, 4)];
      instr($urandom | 32'd4, op, fn, rb(),
            $urandom_range(0, 3),
            $urandom_range(0, 3), lat);
      if ($urandom_range(0, 39) == 0) begin
        do_halt($urandom_range(1, 4));
        do_reset($urandom_range(1, 2));
      end
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
